// File: rtl/mem_bus_master.sv
// mem_bus_master: segment:offset byte/word initiator for a byte-wide synchronous SRAM,
// splitting words into two little-endian byte cycles behind a busy/done handshake.
module mem_bus_master #(
    parameter bit WRAP_OFFSET = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        wide,
    input  logic [15:0] seg,
    input  logic [15:0] off,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic [19:0] address,
    output logic [7:0]  data_out,
    input  logic [7:0]  data_in,
    output logic        write_ena
);
    typedef enum logic [2:0] {IDLE, WR0, WR1, RD0, RD1, RD2} state_t;

    state_t      state_q, state_d;
    logic        wide_q, wide_d;
    logic [7:0]  whi_q, whi_d;
    logic [19:0] ea1_q, ea1_d;
    logic [19:0] address_q, address_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        write_ena_q, write_ena_d;
    logic [15:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic [19:0] ea, ea1;
    logic [15:0] off1;

    assign off1 = off + 16'd1;
    assign ea   = {seg, 4'b0} + {4'b0, off};
    // Real-mode word accesses wrap the offset inside the segment rather than crossing it.
    assign ea1  = WRAP_OFFSET ? {seg, 4'b0} + {4'b0, off1} : ea + 20'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wide_q      <= 1'b0;
            whi_q       <= '0;
            ea1_q       <= '0;
            address_q   <= '0;
            data_out_q  <= '0;
            write_ena_q <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wide_q      <= wide_d;
            whi_q       <= whi_d;
            ea1_q       <= ea1_d;
            address_q   <= address_d;
            data_out_q  <= data_out_d;
            write_ena_q <= write_ena_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wide_d      = wide_q;
        whi_d       = whi_q;
        ea1_d       = ea1_q;
        address_d   = address_q;
        data_out_d  = data_out_q;
        write_ena_d = write_ena_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                wide_d    = wide;
                whi_d     = wdata[15:8];
                ea1_d     = ea1;
                address_d = ea;
                if (we) begin
                    data_out_d  = wdata[7:0];
                    write_ena_d = 1'b1;
                    state_d     = WR0;
                end else begin
                    state_d = RD0;
                end
            end
            WR0: if (wide_q) begin
                address_d  = ea1_q;
                data_out_d = whi_q;
                state_d    = WR1;
            end else begin
                write_ena_d = 1'b0;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            WR1: begin
                write_ena_d = 1'b0;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            RD0: begin
                address_d = wide_q ? ea1_q : address_q;
                state_d   = RD1;
            end
            // The memory returns the low byte here; a word read overlaps the high-byte fetch.
            RD1: begin
                rdata_d[7:0] = data_in;
                if (!wide_q) begin
                    rdata_d[15:8] = 8'h00;
                    done_d        = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = RD2;
                end
            end
            RD2: begin
                rdata_d[15:8] = data_in;
                done_d        = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign address   = address_q;
    assign data_out  = data_out_q;
    assign write_ena = write_ena_q;
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed checks of mem_bus_master against byte-wide SRAM models,
// one instance per WRAP_OFFSET setting driven by the same stimulus.
module tb_mem_bus_master;
    logic        clock = 1'b0, reset = 1'b1;
    logic        req = 1'b0, we = 1'b0, wide = 1'b0;
    logic [15:0] seg = '0, off = '0, wdata = '0;
    logic [15:0] rdata1, rdata0;
    logic        busy1, busy0, done1, done0, wena1, wena0;
    logic [19:0] addr1, addr0;
    logic [7:0]  dout1, dout0, din1, din0;
    logic [7:0]  mem1 [0:1048575];
    logic [7:0]  mem0 [0:1048575];
    int          vecs = 0, errs = 0;

    always #5 clock = ~clock;

    mem_bus_master #(.WRAP_OFFSET(1'b1)) dut1 (
        .clock(clock), .reset(reset), .req(req), .we(we), .wide(wide), .seg(seg), .off(off),
        .wdata(wdata), .rdata(rdata1), .busy(busy1), .done(done1), .address(addr1),
        .data_out(dout1), .data_in(din1), .write_ena(wena1)
    );
    mem_bus_master #(.WRAP_OFFSET(1'b0)) dut0 (
        .clock(clock), .reset(reset), .req(req), .we(we), .wide(wide), .seg(seg), .off(off),
        .wdata(wdata), .rdata(rdata0), .busy(busy0), .done(done0), .address(addr0),
        .data_out(dout0), .data_in(din0), .write_ena(wena0)
    );

    initial begin
        for (int i = 0; i < 1048576; i++) begin
            mem1[i] = 8'h00;
            mem0[i] = 8'h00;
        end
    end

    always @(posedge clock) begin
        if (wena1) mem1[addr1] <= dout1;
        din1 <= mem1[addr1];
        if (wena0) mem0[addr0] <= dout0;
        din0 <= mem0[addr0];
    end

    task automatic start(input logic w, input logic wd, input logic [15:0] s, input logic [15:0] o,
                         input logic [15:0] d);
        @(negedge clock);
        req = 1'b1; we = w; wide = wd; seg = s; off = o; wdata = d;
        @(posedge clock); #1;
        req = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done1 && lat < 10) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        vecs++; if ({busy1, done1, wena1} !== 3'b000) begin errs++; $display("FAIL reset_ctl got %b want 000", {busy1, done1, wena1}); end
        vecs++; if (addr1 !== 20'h0) begin errs++; $display("FAIL reset_addr got %h want 00000", addr1); end
        vecs++; if ({dout1, rdata1} !== 24'h0) begin errs++; $display("FAIL reset_data got %h want 000000", {dout1, rdata1}); end
    endtask

    task automatic test_byte_write;
        int lat;
        start(1'b1, 1'b0, 16'h1234, 16'h0010, 16'h00AB);
        vecs++; if (addr1 !== 20'h12350) begin errs++; $display("FAIL bw_addr got %h want 12350", addr1); end
        vecs++; if (dout1 !== 8'hAB) begin errs++; $display("FAIL bw_dout got %h want ab", dout1); end
        vecs++; if ({wena1, busy1} !== 2'b11) begin errs++; $display("FAIL bw_strobe got %b want 11", {wena1, busy1}); end
        wait_done(lat);
        vecs++; if (lat !== 1) begin errs++; $display("FAIL bw_latency got %0d want 1", lat); end
        vecs++; if (wena1 !== 1'b0) begin errs++; $display("FAIL bw_wena_off got %b want 0", wena1); end
        vecs++; if (mem1[20'h12350] !== 8'hAB) begin errs++; $display("FAIL bw_mem got %h want ab", mem1[20'h12350]); end
    endtask

    task automatic test_word_read;
        int lat;
        start(1'b1, 1'b1, 16'h0000, 16'h0100, 16'h1234);
        wait_done(lat);
        vecs++; if (lat !== 2) begin errs++; $display("FAIL ww_latency got %0d want 2", lat); end
        vecs++; if ({mem1[20'h00101], mem1[20'h00100]} !== 16'h1234) begin errs++; $display("FAIL ww_mem got %h%h want 1234", mem1[20'h00101], mem1[20'h00100]); end
        start(1'b0, 1'b1, 16'h0000, 16'h0100, 16'h0000);
        wait_done(lat);
        vecs++; if (lat !== 3) begin errs++; $display("FAIL wr_latency got %0d want 3", lat); end
        vecs++; if (rdata1 !== 16'h1234) begin errs++; $display("FAIL wr_rdata got %h want 1234", rdata1); end
        start(1'b0, 1'b0, 16'h0000, 16'h0100, 16'h0000);
        wait_done(lat);
        vecs++; if (lat !== 2) begin errs++; $display("FAIL br_latency got %0d want 2", lat); end
        vecs++; if (rdata1 !== 16'h0034) begin errs++; $display("FAIL br_rdata got %h want 0034", rdata1); end
        start(1'b1, 1'b1, 16'h0000, 16'h0500, 16'hCAFE);
        wait_done(lat);
        vecs++; if (rdata1 !== 16'h0034) begin errs++; $display("FAIL rdata_hold got %h want 0034", rdata1); end
    endtask

    task automatic test_offset_wrap;
        int lat;
        start(1'b1, 1'b1, 16'h2000, 16'hFFFF, 16'hBEEF);
        vecs++; if (addr1 !== 20'h2FFFF) begin errs++; $display("FAIL ow_addr got %h want 2ffff", addr1); end
        wait_done(lat);
        vecs++; if (lat !== 2) begin errs++; $display("FAIL ow_latency got %0d want 2", lat); end
        vecs++; if ({mem1[20'h20000], mem1[20'h2FFFF]} !== 16'hBEEF) begin errs++; $display("FAIL ow_mem_wrap got %h%h want beef", mem1[20'h20000], mem1[20'h2FFFF]); end
        vecs++; if (mem1[20'h30000] !== 8'h00) begin errs++; $display("FAIL ow_mem_wrap_lin got %h want 00", mem1[20'h30000]); end
        vecs++; if ({mem0[20'h30000], mem0[20'h2FFFF]} !== 16'hBEEF) begin errs++; $display("FAIL ow_mem_lin got %h%h want beef", mem0[20'h30000], mem0[20'h2FFFF]); end
        vecs++; if (mem0[20'h20000] !== 8'h00) begin errs++; $display("FAIL ow_mem_lin_seg got %h want 00", mem0[20'h20000]); end
        start(1'b0, 1'b1, 16'h2000, 16'hFFFF, 16'h0000);
        wait_done(lat);
        vecs++; if (rdata1 !== 16'hBEEF) begin errs++; $display("FAIL ow_read_wrap got %h want beef", rdata1); end
        vecs++; if (rdata0 !== 16'hBEEF) begin errs++; $display("FAIL ow_read_lin got %h want beef", rdata0); end
    endtask

    task automatic test_addr_wrap;
        int lat;
        start(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0077);
        wait_done(lat);
        start(1'b0, 1'b0, 16'hFFFF, 16'h0010, 16'h0000);
        vecs++; if (addr1 !== 20'h00000) begin errs++; $display("FAIL aw_addr got %h want 00000", addr1); end
        wait_done(lat);
        vecs++; if (lat !== 2) begin errs++; $display("FAIL aw_latency got %0d want 2", lat); end
        vecs++; if (rdata1 !== 16'h0077) begin errs++; $display("FAIL aw_rdata got %h want 0077", rdata1); end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clock);
        req = 1'b1; we = 1'b1; wide = 1'b1; seg = 16'h0000; off = 16'h0200; wdata = 16'hA55A;
        @(posedge clock); #1;
        we = 1'b0;
        wait_done(lat);
        vecs++; if (lat !== 2) begin errs++; $display("FAIL b2b_wr_latency got %0d want 2", lat); end
        vecs++; if (busy1 !== 1'b0) begin errs++; $display("FAIL b2b_idle_in_done got %b want 0", busy1); end
        @(posedge clock); #1;
        req = 1'b0;
        vecs++; if ({busy1, addr1} !== {1'b1, 20'h00200}) begin errs++; $display("FAIL b2b_no_bubble got %b/%h want 1/00200", busy1, addr1); end
        @(negedge clock);
        req = 1'b1; we = 1'b1; wide = 1'b0; off = 16'h0300; wdata = 16'h00FF;
        @(posedge clock); #1;
        req = 1'b0;
        wait_done(lat);
        vecs++; if (lat !== 2) begin errs++; $display("FAIL b2b_rd_latency got %0d want 2", lat); end
        vecs++; if (rdata1 !== 16'hA55A) begin errs++; $display("FAIL b2b_rdata got %h want a55a", rdata1); end
        @(posedge clock); #1;
        vecs++; if (busy1 !== 1'b0) begin errs++; $display("FAIL b2b_ignored_busy got %b want 0", busy1); end
        vecs++; if (mem1[20'h00300] !== 8'h00) begin errs++; $display("FAIL b2b_ignored_mem got %h want 00", mem1[20'h00300]); end
    endtask

    task automatic test_reset_mid_write;
        int lat;
        start(1'b1, 1'b1, 16'h0000, 16'h0400, 16'h1357);
        @(posedge clock); #1;
        vecs++; if ({wena1, addr1} !== {1'b1, 20'h00401}) begin errs++; $display("FAIL rm_wr1 got %b/%h want 1/00401", wena1, addr1); end
        reset = 1'b1;
        @(posedge clock); #1;
        vecs++; if ({wena1, busy1, done1} !== 3'b000) begin errs++; $display("FAIL rm_ctl got %b want 000", {wena1, busy1, done1}); end
        vecs++; if ({addr1, dout1, rdata1} !== 44'h0) begin errs++; $display("FAIL rm_outs got %h want 0", {addr1, dout1, rdata1}); end
        reset = 1'b0;
        @(posedge clock); #1;
        vecs++; if (done1 !== 1'b0) begin errs++; $display("FAIL rm_no_done got %b want 0", done1); end
        start(1'b0, 1'b0, 16'h0000, 16'h0400, 16'h0000);
        wait_done(lat);
        vecs++; if (lat !== 2) begin errs++; $display("FAIL rm_after_latency got %0d want 2", lat); end
        vecs++; if (rdata1 !== 16'h0057) begin errs++; $display("FAIL rm_after_rdata got %h want 0057", rdata1); end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        test_reset;
        reset = 1'b0;
        test_byte_write;
        test_word_read;
        test_offset_wrap;
        test_addr_wrap;
        test_back_to_back;
        test_reset_mid_write;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side initiator for the byte-wide synchronous SRAM port: drives `address` / `data_out` / `write_ena` and samples `data_in`.
- Takes segment:offset byte or word requests from the x86 core and forms the 20-bit physical address.
- Splits a word access into two little-endian byte cycles and hides the memory's one-cycle read latency behind a busy/done handshake.

Parameters:
- WRAP_OFFSET, 1, 1: the high byte of a word uses (off+1) mod 2^16 within the segment (x86 real mode). 0: the high byte uses linear ea+1 mod 2^20.

Ports:
- clock  in  1  system clock; every register updates on its rising edge
- reset  in  1  synchronous reset, active-high
- req  in  1  access request; sampled only while busy=0
- we  in  1  1 = write, 0 = read; sampled with req
- wide  in  1  1 = 16-bit word, 0 = byte; sampled with req
- seg  in  16  segment; sampled with req
- off  in  16  offset; sampled with req
- wdata  in  16  write data, low byte at ea; sampled with req
- rdata  out  16  read result; byte reads are zero-extended
- busy  out  1  high while an access is in progress (state != IDLE)
- done  out  1  one-cycle pulse when an access completes
- address  out  20  SRAM byte address
- data_out  out  8  SRAM write data
- data_in  in  8  SRAM read data, valid one edge after address is presented
- write_ena  out  1  SRAM write strobe; the write commits on the edge where it is high

Behaviour:
- Reset: state=IDLE. address=0, data_out=0, write_ena=0, rdata=0, done=0, busy=0. Reset overrides everything.
- Reset mid-access: the access is abandoned and write_ena falls at the reset edge. A word write may leave only the low byte committed; this is accepted, and no done is issued.
- ea = (seg<<4) + off, truncated to 20 bits, so FFFF:0010 maps to 0x00000. ea1 is the high-byte address, per WRAP_OFFSET.
- All outputs are registered; done is cleared on every edge unless set by a completing state.
- States: IDLE, WR0, WR1, RD0, RD1, RD2.
- IDLE, req=1 at edge E0: latch we, wide, wdata and ea1; address<=ea.
  - we=1: data_out<=wdata[7:0], write_ena<=1, go WR0.
  - we=0: go RD0.
  - req=0: stay in IDLE.
- WR0: the memory writes the low byte at edge E0+1.
  - wide=1: address<=ea1, data_out<=wdata[15:8], write_ena stays 1, go WR1.
  - wide=0: write_ena<=0, done<=1, go IDLE.
- WR1: the memory writes the high byte at edge E0+2. At that edge write_ena<=0, done<=1, go IDLE.
- RD0: the memory captures sram[ea] at E0+1. If wide=1, address<=ea1 at the same edge. Go RD1.
- RD1: data_in = byte at ea. At E0+2, rdata[7:0]<=data_in.
  - wide=0: rdata[15:8]<=0, done<=1, go IDLE.
  - wide=1: go RD2. The memory captures sram[ea1] at this same edge.
- RD2: at E0+3, rdata[15:8]<=data_in, done<=1, go IDLE.
- Latency from the accepting edge E0 to done high: byte write 1, word write 2, byte read 2, word read 3.
- rdata is stable from the done edge until the next read completes. Writes never alter rdata.
- req while busy is ignored and not queued. req in the done cycle is accepted, since the state is already IDLE, which gives back-to-back accesses with no bubble.
- address holds its last value while idle; data_out changes only on writes.

Test Plan:
- Byte write: seg=0x1234, off=0x0010, wdata=0x00AB, we=1, wide=0 -> one cycle with address=0x12350, data_out=0xAB, write_ena=1; done one edge after accept; sram[0x12350]=0xAB.
- Word read: sram[0x00100]=0x34, sram[0x00101]=0x12, seg=0, off=0x0100, wide=1 -> done 3 edges after accept, rdata=0x1234; byte read at the same address gives rdata=0x0034 after 2 edges.
- Offset wrap: word write, seg=0x2000, off=0xFFFF, wdata=0xBEEF, WRAP_OFFSET=1 -> sram[0x2FFFF]=0xEF, sram[0x20000]=0xBE. With WRAP_OFFSET=0 the high byte instead lands at 0x30000.
- 20-bit wrap: byte read, seg=0xFFFF, off=0x0010 -> address=0x00000; rdata=sram[0].
- Handshake: hold req=1 continuously with alternating write/read to 0x00200 -> a new access starts on each done edge; req pulses during busy are ignored; read-after-write returns the written word.
- Reset mid-word-write, asserted during WR1 -> the next edge has write_ena=0, busy=0, done=0 and all outputs at reset values; a following access proceeds normally.
